// File: rtl/seg_pkg.sv
// Shared constants, state encodings and helpers for the 7-segment scan controller.
package seg_pkg;

  // All segments off (active-low bus)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Scan state encodings
  localparam logic [1:0] SEG_STATE_IDLE  = 2'd0;
  localparam logic [1:0] SEG_STATE_GUARD = 2'd1;
  localparam logic [1:0] SEG_STATE_ON    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = SEG_STATE_IDLE,
    ST_GUARD = SEG_STATE_GUARD,
    ST_ON    = SEG_STATE_ON
  } seg_state_e;

  // True for decimal digit codes 0..9
  function automatic logic bcd_valid(input logic [3:0] nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage

// File: rtl/decoder.sv
// BCD to active-low 7-segment decoder; [6]=a ... [0]=g, codes 10..15 blank.
module decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  // Pure lookup, no state
  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = 7'h01;
      4'd1:    seg_c = 7'h4F;
      4'd2:    seg_c = 7'h12;
      4'd3:    seg_c = 7'h06;
      4'd4:    seg_c = 7'h4C;
      4'd5:    seg_c = 7'h24;
      4'd6:    seg_c = 7'h20;
      4'd7:    seg_c = 7'h0F;
      4'd8:    seg_c = 7'h00;
      4'd9:    seg_c = 7'h04;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Optional build macro: SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned DW     = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned SLOT_W = $clog2(REFRESH_DIV);

  seg_state_e          state, state_nxt;
  logic [SLOT_W-1:0]   slot_cnt, slot_nxt;
  logic [IDX_W-1:0]    digit_idx, idx_nxt;
  logic [DW-1:0]       disp_reg, disp_nxt;
  logic [DW-1:0]       pend_reg, pend_nxt;
  logic                pend_full, pend_full_nxt;
  logic [6:0]          seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic                frame_done_nxt;

  logic                accept;
  logic                slot_last;
  logic                frame_end;
  logic [3:0]          cur_nibble;
  logic [6:0]          dec_seg;
  logic [6:0]          cur_pat;

  assign accept     = load_valid & load_ready;
  assign slot_last  = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
  assign frame_end  = slot_last && (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign cur_nibble = disp_reg[{digit_idx, 2'b00} +: 4];

  decoder u_decoder (
    .bcd   (cur_nibble),
    .seg_c (dec_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_mask;

  // Digits above the most significant nonzero digit; digit 0 never blanked
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above && (v[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

  // Mask follows disp_reg so it is always consistent with the shown value
  always_ff @(posedge clk) begin
    if (rst) blank_mask <= lz_mask('0);
    else     blank_mask <= lz_mask(disp_nxt);
  end

  assign cur_pat = (!bcd_valid(cur_nibble) || blank_mask[digit_idx]) ? SEG_BLANK : dec_seg;
`else
  assign cur_pat = bcd_valid(cur_nibble) ? dec_seg : SEG_BLANK;
`endif

  // Next-state, counters, load buffering and output next-values
  always_comb begin
    state_nxt      = state;
    slot_nxt       = slot_cnt;
    idx_nxt        = digit_idx;
    disp_nxt       = disp_reg;
    pend_nxt       = pend_reg;
    pend_full_nxt  = pend_full;
    seg_nxt        = SEG_BLANK;
    an_nxt         = '1;
    frame_done_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        slot_nxt = '0;
        idx_nxt  = '0;
        if (accept) disp_nxt = bcd_in;
        if (enable) state_nxt = ST_GUARD;
      end
      default: begin
        if (!enable) begin
          // Drop to idle immediately; pending data survives for the next run
          state_nxt = ST_IDLE;
          slot_nxt  = '0;
          idx_nxt   = '0;
          if (accept) begin
            pend_nxt      = bcd_in;
            pend_full_nxt = 1'b1;
          end
        end else begin
          seg_nxt = cur_pat;
          if (state == ST_ON) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
              if (digit_idx == IDX_W'(i)) an_nxt[i] = 1'b0;
            end
          end

          if (slot_last) begin
            slot_nxt = '0;
            idx_nxt  = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
          end else begin
            slot_nxt = slot_cnt + SLOT_W'(1);
          end
          state_nxt = (slot_nxt < SLOT_W'(GUARD_CYCLES)) ? ST_GUARD : ST_ON;

          if (frame_end) begin
            frame_done_nxt = 1'b1;
            if (pend_full) begin
              disp_nxt      = pend_reg;
              pend_full_nxt = 1'b0;
            end
          end

          if (accept) begin
            pend_nxt      = bcd_in;
            pend_full_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      slot_cnt   <= '0;
      digit_idx  <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_full  <= 1'b0;
      load_ready <= 1'b1;
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      slot_cnt   <= slot_nxt;
      digit_idx  <= idx_nxt;
      disp_reg   <= disp_nxt;
      pend_reg   <= pend_nxt;
      pend_full  <= pend_full_nxt;
      load_ready <= ~pend_full_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a positional reference model.
// Build with +define+SEG_LZ_BLANK_EN to also check leading-zero blanking.
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 20;
  localparam int G  = 2;
  localparam int FR = N * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] bcd_in;
  logic        load_valid;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bcd_in     (bcd_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pos = cycles since scanning began (-1 when idle)
  int          pos;
  logic [15:0] shown;
  logic [15:0] pend;
  logic        pend_v;

  // Active-low a..g patterns for digits 0..9
  logic [6:0] pat [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                           7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg_for(input logic [15:0] v, input int d);
    logic [3:0]  nib;
    logic [15:0] upper;
    nib   = v[4*d +: 4];
    upper = v >> (4 * d);
`ifdef SEG_LZ_BLANK_EN
    if (d > 0 && upper == 16'h0) return 7'h7F;
`else
    if (upper == 16'hFFFF && d < 0) return 7'h7F;
`endif
    if (nib > 4'd9) return 7'h7F;
    return pat[int'(nib)];
  endfunction

  // One clock: predict outputs from model, advance model, then compare
  task automatic step();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic [3:0] one_hot;
    logic       e_fd;
    logic       acc;
    int         d;
    int         s;
    if (rst) begin
      e_seg = 7'h7F; e_an = 4'hF; e_fd = 1'b0;
      shown = 16'h0; pend_v = 1'b0; pos = -1;
    end else begin
      acc = load_valid && !pend_v;
      if (pos < 0 || !enable) begin
        e_seg = 7'h7F; e_an = 4'hF; e_fd = 1'b0;
      end else begin
        d       = (pos / RD) % N;
        s       = pos % RD;
        one_hot = 4'b0001 << d;
        e_seg   = exp_seg_for(shown, d);
        e_an    = (s < G) ? 4'hF : ~one_hot;
        e_fd    = ((pos % FR) == FR - 1);
      end
      if (pos < 0) begin
        if (acc) shown = bcd_in;
        pos = enable ? 0 : -1;
      end else if (!enable) begin
        pos = -1;
        if (acc) begin pend = bcd_in; pend_v = 1'b1; end
      end else begin
        if ((pos % FR) == FR - 1 && pend_v) begin
          shown  = pend;
          pend_v = 1'b0;
        end
        if (acc) begin pend = bcd_in; pend_v = 1'b1; end
        pos++;
      end
    end
    @(posedge clk);
    #1;
    chk("seg", 16'(seg), 16'(e_seg));
    chk("an", 16'(an), 16'(e_an));
    chk("frame_done", 16'(frame_done), 16'(e_fd));
    chk("load_ready", 16'(load_ready), 16'(!pend_v));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load_idle(input logic [15:0] v);
    enable = 1'b0;
    run(2);
    bcd_in = v; load_valid = 1'b1;
    run(1);
    load_valid = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; bcd_in = 16'h0;
    pos = -1; shown = 16'h0; pend = 16'h0; pend_v = 1'b0;
    run(3);
    rst = 1'b0;
    run(2);

    // Reset and first digit with 1234
    load_idle(16'h1234);
    run(2 * FR + 10);

    // Mid-frame load, then back-pressure with a second value
    bcd_in = 16'h5678; load_valid = 1'b1;
    run(1);
    bcd_in = 16'h9012;
    run(FR + 10);
    load_valid = 1'b0;
    run(2 * FR);

    // Invalid codes
    bcd_in = 16'hFA90; load_valid = 1'b1;
    run(1);
    load_valid = 1'b0;
    run(2 * FR);

    // Load accepted on the boundary cycle waits one full frame
    for (int k = 0; k < FR && (pos % FR) != FR - 1; k++) step();
    bcd_in = 16'h4321; load_valid = 1'b1;
    run(1);
    load_valid = 1'b0;
    run(2 * FR + 5);

    // Disable during digit 2, then re-enable
    for (int k = 0; k < FR && !(((pos / RD) % N) == 2 && (pos % RD) >= G + 3); k++) step();
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(30);

    // Reset during ON with a load attempted on the same cycle
    for (int k = 0; k < RD && (pos % RD) < G + 1; k++) step();
    rst = 1'b1; bcd_in = 16'h8888; load_valid = 1'b1;
    run(1);
    rst = 1'b0; load_valid = 1'b0;
    run(FR + 5);

    // Leading-zero cases (plain display when blanking is not built)
    load_idle(16'h0070);
    run(FR + 5);
    load_idle(16'h0000);
    run(FR + 5);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 499) == 0);
      enable     = ($urandom_range(0, 199) != 0);
      load_valid = ($urandom_range(0, 39) == 0);
      bcd_in     = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
